// File: rtl/decoder_pkg.sv
// Shared definitions for the N-to-2^N decoder family: mode encodings and
// the output-width helper used to size the one-hot/thermometer bus.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DEC     = 2'b00,
    MODE_THERM   = 2'b01,
    MODE_SCAN_UP = 2'b10,
    MODE_SCAN_DN = 2'b11
  } mode_e;

  // Number of decoded output lines for an n-bit select.
  function automatic int out_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/decoder_nto2n_scan_tick_gen.sv
// Scan prescaler: counts enabled cycles 0..PRESCALE-1 and flags the
// terminal count as a step request. clr restarts the count so the first
// step after a load lands a full PRESCALE cycles later.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic          at_term;

  assign at_term = (cnt == TERM);

  // A clear suppresses the step so a load is never followed by an
  // immediate move of the index in the same cycle.
  assign tick = en & ~clr & at_term;

  // Prescaler count; holds whenever en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_term ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N decoder with one-hot, thermometer and auto-scan
// modes. In scan modes an index counter, paced by tick_gen, walks the
// one-hot output up or down for digit/row multiplexing.
module decoder_nto2n_scan
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [N-1:0]            in,
  input  logic                    load,
  output logic [out_width(N)-1:0] out,
  output logic [N-1:0]            idx,
  output logic                    wrap
);

  localparam int W = out_width(N);

  logic          scan_mode;
  logic          step;
  logic [N-1:0]  idx_next;
  logic          wrap_next;
  logic [W-1:0]  out_next;
  logic [W-1:0]  out_p1;
  logic          wrap_p1;

  // One-hot decode of a select value.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
    logic [W-1:0] o;
    o    = '0;
    o[v] = 1'b1;
    return o;
  endfunction

  // Thermometer decode: every line at or below the select value is set.
  function automatic logic [W-1:0] therm(input logic [N-1:0] v);
    logic [W-1:0] t;
    t = '0;
    for (int k = 0; k < W; k++) begin
      t[k] = (k <= int'(v));
    end
    return t;
  endfunction

  assign scan_mode = mode[1];

  // The prescaler only advances while scanning; a load (when enabled)
  // restarts it from any mode.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en & scan_mode),
    .clr  (en & load),
    .tick (step)
  );

  // Next index, wrap flag and decoded output; load beats a step and en
  // low freezes everything while blanking the output.
  always_comb begin
    idx_next  = idx;
    wrap_next = 1'b0;
    out_next  = '0;
    if (en) begin
      if (load) begin
        idx_next = in;
      end else if (scan_mode && step) begin
        if (mode == MODE_SCAN_UP) begin
          idx_next  = idx + N'(1);
          wrap_next = (idx == '1);
        end else begin
          idx_next  = idx - N'(1);
          wrap_next = (idx == '0);
        end
      end
      case (mode)
        MODE_DEC:   out_next = onehot(in);
        MODE_THERM: out_next = therm(in);
        default:    out_next = onehot(idx_next);
      endcase
    end
  end

  // Output, index and wrap registers; the index register drives idx
  // directly so out and idx always describe the same step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      out_p1  <= '0;
      wrap_p1 <= 1'b0;
    end else begin
      idx     <= idx_next;
      out_p1  <= out_next;
      wrap_p1 <= wrap_next;
    end
  end

  // Polarity is applied after the register so reset still reads inactive.
  assign out  = ACTIVE_LOW ? ~out_p1 : out_p1;
  assign wrap = wrap_p1;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Bench for decoder_nto2n_scan: three N=3 instances with different
// prescale/polarity share one stimulus stream; a behavioural model per
// instance is compared every cycle, plus directed literal expectations.
module tb_decoder_nto2n_scan;

  localparam int P0 = 2;
  localparam int P1 = 1;
  localparam int P2 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] in = 3'd0;
  logic       load = 1'b0;

  logic [7:0] out0, out1, out2;
  logic [2:0] idx0, idx1, idx2;
  logic       wrap0, wrap1, wrap2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_nto2n_scan #(.N(3), .PRESCALE(P0), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .load(load),
    .out(out0), .idx(idx0), .wrap(wrap0));

  decoder_nto2n_scan #(.N(3), .PRESCALE(P1), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .load(load),
    .out(out1), .idx(idx1), .wrap(wrap1));

  decoder_nto2n_scan #(.N(3), .PRESCALE(P2), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in), .load(load),
    .out(out2), .idx(idx2), .wrap(wrap2));

  // ---------------- behavioural model ----------------
  typedef struct {
    int         idx;
    int         pre;
    logic [7:0] out;
    logic       wrap;
  } mstate_t;

  mstate_t m0, m1, m2;

  function automatic mstate_t model_reset(input bit al);
    mstate_t r;
    r.idx  = 0;
    r.pre  = 0;
    r.out  = al ? 8'hFF : 8'h00;
    r.wrap = 1'b0;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input int p, input bit al,
                                         input logic e, input logic [1:0] md,
                                         input int v, input logic ld);
    mstate_t n;
    int o;
    n = s;
    n.wrap = 1'b0;
    if (!e) begin
      n.out = al ? 8'hFF : 8'h00;
      return n;
    end
    if (ld) begin
      n.idx = v;
      n.pre = 0;
    end else if (md >= 2) begin
      if (s.pre == p - 1) begin
        n.pre = 0;
        if (md == 2) begin
          n.idx  = (s.idx + 1) % 8;
          n.wrap = (s.idx == 7);
        end else begin
          n.idx  = (s.idx + 7) % 8;
          n.wrap = (s.idx == 0);
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    if (md == 0)      o = 1 << v;
    else if (md == 1) o = (1 << (v + 1)) - 1;
    else              o = 1 << n.idx;
    n.out = al ? ~8'(o) : 8'(o);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= model_reset(1'b0);
      m1 <= model_reset(1'b0);
      m2 <= model_reset(1'b1);
    end else begin
      m0 <= model_next(m0, P0, 1'b0, en, mode, int'(in), load);
      m1 <= model_next(m1, P1, 1'b0, en, mode, int'(in), load);
      m2 <= model_next(m2, P2, 1'b1, en, mode, int'(in), load);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic [7:0] o, input logic [2:0] x,
                          input logic w, input mstate_t s);
    chk($sformatf("u%0d.out", i), {24'd0, o}, {24'd0, s.out});
    chk($sformatf("u%0d.idx", i), {29'd0, x}, s.idx);
    chk($sformatf("u%0d.wrap", i), {31'd0, w}, {31'd0, s.wrap});
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    chk_inst(0, out0, idx0, wrap0, m0);
    chk_inst(1, out1, idx1, wrap1, m1);
    chk_inst(2, out2, idx2, wrap2, m2);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_dn_idx [3];
    logic exp_dn_w [3];
    exp_dn_idx = '{1, 0, 7};
    exp_dn_w   = '{1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out0", {24'd0, out0}, 32'h00);
    chk("rst_out2_al", {24'd0, out2}, 32'hFF);
    chk("rst_idx0", {29'd0, idx0}, 0);
    chk("rst_wrap0", {31'd0, wrap0}, 0);

    // Plain decode
    rst_n = 1'b1; en = 1'b1; mode = 2'b00; in = 3'd5;
    @(negedge clk);
    chk("dec5", {24'd0, out0}, 32'h20);
    in = 3'd0;
    @(negedge clk);
    chk("dec0", {24'd0, out0}, 32'h01);

    // Thermometer
    mode = 2'b01; in = 3'd3;
    @(negedge clk);
    chk("therm3", {24'd0, out0}, 32'h0F);
    chk("therm3_al", {24'd0, out2}, 32'hF0);
    in = 3'd7;
    @(negedge clk);
    chk("therm7", {24'd0, out0}, 32'hFF);
    chk("therm7_al", {24'd0, out2}, 32'h00);

    // Scan-up from reset, PRESCALE=2 instance
    rst_n = 1'b0; mode = 2'b10; in = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("up_idx", {29'd0, idx0}, (k / 2) % 8);
      chk("up_out", {24'd0, out0}, 1 << ((k / 2) % 8));
      chk("up_wrap", {31'd0, wrap0}, (k == 16) ? 1 : 0);
    end

    // Load then scan-down, PRESCALE=1 instance
    load = 1'b1; in = 3'd2; mode = 2'b11;
    @(negedge clk);
    chk("dn_load_idx", {29'd0, idx1}, 2);
    chk("dn_load_out", {24'd0, out1}, 32'h04);
    chk("dn_load_wrap", {31'd0, wrap1}, 0);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dn_idx", {29'd0, idx1}, exp_dn_idx[k]);
      chk("dn_out", {24'd0, out1}, 1 << exp_dn_idx[k]);
      chk("dn_wrap", {31'd0, wrap1}, {31'd0, exp_dn_w[k]});
    end

    // Load on a terminal-count cycle wins over the step
    load = 1'b1; in = 3'd5;
    @(negedge clk);
    chk("ld_term_u1", {29'd0, idx1}, 5);
    chk("ld_term_u1_wrap", {31'd0, wrap1}, 0);
    load = 1'b0;
    @(negedge clk);
    load = 1'b1; in = 3'd3;
    @(negedge clk);
    chk("ld_term_u0", {29'd0, idx0}, 3);
    chk("ld_term_u1b", {29'd0, idx1}, 3);

    // Enable gating mid-scan (u0: idx 3, prescaler 0 after the load)
    load = 1'b0; mode = 2'b10;
    repeat (3) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("gap_out0", {24'd0, out0}, 32'h00);
      chk("gap_out2_al", {24'd0, out2}, 32'hFF);
      chk("gap_idx0", {29'd0, idx0}, 4);
      chk("gap_wrap0", {31'd0, wrap0}, 0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_idx0", {29'd0, idx0}, 5);
    chk("resume_out0", {24'd0, out0}, 32'h20);

    // Asynchronous reset mid-scan with idx = 6 on the PRESCALE=1 instance
    load = 1'b1; in = 3'd5;
    @(negedge clk);
    chk("pre_rst_idx1", {29'd0, idx1}, 5);
    load = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_idx1b", {29'd0, idx1}, 6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_idx1", {29'd0, idx1}, 0);
    chk("arst_out1", {24'd0, out1}, 32'h00);
    chk("arst_wrap1", {31'd0, wrap1}, 0);
    chk("arst_out2_al", {24'd0, out2}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_idx0", {29'd0, idx0}, 0);
    chk("restart_out0", {24'd0, out0}, 32'h01);
    chk("restart_idx1", {29'd0, idx1}, 1);
    @(negedge clk);
    chk("restart_idx0b", {29'd0, idx0}, 1);
    chk("restart_out0b", {24'd0, out0}, 32'h02);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
